// File: rtl/counter_seq_ctrl_if.sv
// Command byte channel into the counter sequencer: valid/ready handshake
// carrying a 3-bit opcode and a WIDTH-bit operand.
interface counter_seq_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [WIDTH-1:0] cmd_data;

    modport master (output cmd_valid, output cmd_op, output cmd_data, input  cmd_ready);
    modport slave  (input  cmd_valid, input  cmd_op, input  cmd_data, output cmd_ready);
endinterface

// File: rtl/counter_seq_ctrl.sv
// Command-driven sequencer for an external counter. Holds period/prescale
// config, issues clear/increment strobes against the observed counter value,
// and supports free-running and one-shot operation.
module counter_seq_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ena,
    counter_seq_ctrl_if.slave      cmd,
    input  logic [WIDTH-1:0]       cnt_val,
    output logic                   cnt_inc,
    output logic                   cnt_clr,
    output logic                   wrap,
    output logic                   busy,
    output logic                   done,
    output logic                   cmd_err
);
    localparam logic [2:0] OP_NOP      = 3'd0;
    localparam logic [2:0] OP_SET_PER  = 3'd1;
    localparam logic [2:0] OP_SET_PRE  = 3'd2;
    localparam logic [2:0] OP_START    = 3'd3;
    localparam logic [2:0] OP_STOP     = 3'd4;
    localparam logic [2:0] OP_ONESHOT  = 3'd5;

    typedef enum logic [1:0] {IDLE, RUN, SHOT, HOLD} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] period_r;
    logic [WIDTH-1:0] prescale_r;
    logic [WIDTH-1:0] pre_cnt;
    logic             clr_pend;

    logic acc;
    logic active;
    logic ev;
    logic hit;

    // A command is taken whenever the block is enabled; ready has no other gating.
    assign cmd.cmd_ready = ena;
    assign acc    = ena & cmd.cmd_valid;
    assign active = ena && (state == RUN || state == SHOT);
    assign ev     = (pre_cnt == prescale_r);
    // >= so a period lowered below the live count still wraps on the next event.
    assign hit    = (cnt_val >= period_r);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state: one-shot completes on its wrap; accepted commands override.
    always_comb begin
        state_nxt = state;
        if (ena) begin
            if (state == SHOT && wrap) state_nxt = HOLD;
            if (acc) begin
                case (cmd.cmd_op)
                    OP_START:   state_nxt = RUN;
                    OP_ONESHOT: state_nxt = SHOT;
                    OP_STOP:    state_nxt = IDLE;
                    default:    state_nxt = state_nxt;
                endcase
            end
        end
    end

    // Outputs: pending clear wins, otherwise strobe only on a prescale event.
    always_comb begin
        cnt_inc = 1'b0;
        cnt_clr = 1'b0;
        wrap    = 1'b0;
        if (active) begin
            if (clr_pend) begin
                cnt_clr = 1'b1;
            end else if (ev) begin
                if (hit) begin
                    cnt_clr = 1'b1;
                    wrap    = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
        end
        busy = (state == RUN) || (state == SHOT);
        done = (state == HOLD);
    end

    // Config, prescaler, pending-clear and error pulse; commands applied last so they win.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            period_r   <= '1;
            prescale_r <= '0;
            pre_cnt    <= '0;
            clr_pend   <= 1'b0;
            cmd_err    <= 1'b0;
        end else begin
            cmd_err <= acc & cmd.cmd_op[2] & cmd.cmd_op[1];
            if (ena) begin
                if (active) begin
                    if (clr_pend) begin
                        clr_pend <= 1'b0;
                        pre_cnt  <= '0;
                    end else begin
                        pre_cnt <= ev ? '0 : pre_cnt + WIDTH'(1);
                    end
                end
                if (acc) begin
                    case (cmd.cmd_op)
                        OP_SET_PER: period_r   <= cmd.cmd_data;
                        OP_SET_PRE: prescale_r <= cmd.cmd_data;
                        OP_START, OP_ONESHOT: begin
                            clr_pend <= 1'b1;
                            pre_cnt  <= '0;
                        end
                        OP_STOP:    clr_pend <= 1'b0;
                        default:    ;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Directed bench for counter_seq_ctrl with a behavioural counter closing the loop.
module tb_counter_seq_ctrl;
    localparam logic [5:0] NONE = 6'b000000;
    localparam logic [5:0] INC  = 6'b100100;  // inc + busy
    localparam logic [5:0] CLR  = 6'b010100;  // clr + busy
    localparam logic [5:0] WRP  = 6'b011100;  // clr + wrap + busy
    localparam logic [5:0] BSY  = 6'b000100;
    localparam logic [5:0] DN   = 6'b000010;
    localparam logic [5:0] ERR  = 6'b000001;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] cnt_val = 8'd0;
    logic       cnt_inc, cnt_clr, wrap, busy, done, cmd_err;
    int         n_vec = 0;
    int         n_err = 0;

    counter_seq_ctrl_if #(.WIDTH(8)) cif ();

    counter_seq_ctrl #(.WIDTH(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .cmd     (cif),
        .cnt_val (cnt_val),
        .cnt_inc (cnt_inc),
        .cnt_clr (cnt_clr),
        .wrap    (wrap),
        .busy    (busy),
        .done    (done),
        .cmd_err (cmd_err)
    );

    always #5 clk = ~clk;

    // Counter datapath being sequenced.
    always @(posedge clk) begin
        if (cnt_clr)      cnt_val <= 8'd0;
        else if (cnt_inc) cnt_val <= cnt_val + 8'd1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check one cycle's outputs (cv<0 skips the counter value), then advance.
    task automatic cyc(input string tag, input logic [5:0] exp, input int cv);
        #1;
        chk({tag, ".flags"}, {26'd0, cnt_inc, cnt_clr, wrap, busy, done, cmd_err}, {26'd0, exp});
        chk({tag, ".ready"}, {31'd0, cif.cmd_ready}, {31'd0, ena});
        if (cv >= 0) chk({tag, ".cnt"}, {24'd0, cnt_val}, cv);
        @(negedge clk);
    endtask

    task automatic send(input logic [2:0] op, input logic [7:0] data);
        cif.cmd_valid = 1'b1;
        cif.cmd_op    = op;
        cif.cmd_data  = data;
        @(negedge clk);
        cif.cmd_valid = 1'b0;
        cif.cmd_op    = 3'd0;
        cif.cmd_data  = 8'd0;
    endtask

    initial begin
        rst_n = 1'b0;
        ena = 1'b1;
        cif.cmd_valid = 1'b0;
        cif.cmd_op = 3'd0;
        cif.cmd_data = 8'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Reset then idle
        for (int i = 0; i < 20; i++) cyc("idle", NONE, 0);
        ena = 1'b0;
        cyc("idle_dis", NONE, 0);
        ena = 1'b1;
        // Illegal op 7 while idle
        cif.cmd_valid = 1'b1; cif.cmd_op = 3'd7;
        cyc("ill7", NONE, 0);
        cif.cmd_valid = 1'b0; cif.cmd_op = 3'd0;
        cyc("ill7_err", ERR, 0);
        cyc("ill7_gone", NONE, 0);

        // Free-run: period 3, prescale 0
        send(3'd1, 8'd3); send(3'd2, 8'd0); send(3'd3, 8'd0);
        cyc("fr_clr", CLR, 0);
        cyc("fr_i0", INC, 0); cyc("fr_i1", INC, 1); cyc("fr_i2", INC, 2); cyc("fr_w", WRP, 3);
        cyc("fr_i0b", INC, 0); cyc("fr_i1b", INC, 1); cyc("fr_i2b", INC, 2); cyc("fr_wb", WRP, 3);
        send(3'd4, 8'd0);

        // Prescale: period 2, prescale 2, with an ena gap mid-run
        send(3'd1, 8'd2); send(3'd2, 8'd2); send(3'd3, 8'd0);
        cyc("ps_clr", CLR, 1);
        cyc("ps_n0", BSY, 0); cyc("ps_n1", BSY, 0); cyc("ps_i0", INC, 0); cyc("ps_n2", BSY, 1);
        ena = 1'b0;
        for (int i = 0; i < 5; i++) cyc("ps_frozen", BSY, 1);
        ena = 1'b1;
        cyc("ps_n3", BSY, 1); cyc("ps_i1", INC, 1); cyc("ps_n4", BSY, 2); cyc("ps_n5", BSY, 2);
        cyc("ps_w", WRP, 2); cyc("ps_n6", BSY, 0); cyc("ps_n7", BSY, 0); cyc("ps_i2", INC, 0);
        send(3'd4, 8'd0);

        // One-shot: period 1, prescale 0
        send(3'd1, 8'd1); send(3'd2, 8'd0); send(3'd5, 8'd0);
        cyc("os_clr", CLR, 1); cyc("os_i", INC, 0); cyc("os_w", WRP, 1);
        cyc("os_hold0", DN, 0); cyc("os_hold1", DN, 0); cyc("os_hold2", DN, 0);
        cif.cmd_valid = 1'b1; cif.cmd_op = 3'd3;
        cyc("os_start", DN, 0);
        cif.cmd_valid = 1'b0; cif.cmd_op = 3'd0;
        cyc("os_rclr", CLR, 0); cyc("os_ri", INC, 0); cyc("os_rw", WRP, 1);
        send(3'd4, 8'd0);

        // Live reconfig: period 10, lower to 4 at count 7
        send(3'd1, 8'd10); send(3'd3, 8'd0);
        cyc("lr_clr", CLR, 1);
        for (int i = 0; i < 7; i++) cyc("lr_inc", INC, i);
        cif.cmd_valid = 1'b1; cif.cmd_op = 3'd1; cif.cmd_data = 8'd4;
        cyc("lr_set", INC, 7);
        cif.cmd_valid = 1'b0; cif.cmd_op = 3'd0; cif.cmd_data = 8'd0;
        cyc("lr_w", WRP, 8);
        for (int i = 0; i < 4; i++) cyc("lr_inc4", INC, i);
        cyc("lr_w4", WRP, 4);
        send(3'd4, 8'd0);
        for (int i = 0; i < 3; i++) cyc("lr_stop", NONE, 1);

        // Period 0, prescale 1: clear every event, no increments
        send(3'd1, 8'd0); send(3'd2, 8'd1); send(3'd3, 8'd0);
        cyc("p0_clr", CLR, 1); cyc("p0_n0", BSY, 0); cyc("p0_w0", WRP, 0);
        cyc("p0_n1", BSY, 0); cyc("p0_w1", WRP, 0);
        send(3'd4, 8'd0);

        // Illegal op 6 in RUN, then reset mid-run
        send(3'd1, 8'd3); send(3'd2, 8'd0); send(3'd3, 8'd0);
        cyc("il_clr", CLR, 0); cyc("il_i0", INC, 0);
        cif.cmd_valid = 1'b1; cif.cmd_op = 3'd6;
        cyc("il_cmd", INC, 1);
        cif.cmd_valid = 1'b0; cif.cmd_op = 3'd0;
        cyc("il_err", INC | ERR, 2);
        cyc("il_w", WRP, 3); cyc("il_i3", INC, 0);
        rst_n = 1'b0;
        cyc("rst_cyc", INC, 1);
        rst_n = 1'b1;
        cyc("rst_idle0", NONE, 2); cyc("rst_idle1", NONE, 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
